mem_step_sequencer: RTL
=======================

# mem_step_sequencer

Hardwired control-step sequencer for the one-bus CPU datapath. Replaces hand-driven T0–T7 control waveforms with a state machine that fetches an instruction, decodes its opcode and issues the per-step datapath enables for `ld`, `ldi` and `st`. It also inserts memory wait states through a `mem_ready` handshake. It sits between the instruction register opcode field and the datapath enable inputs.

## Interface
Parameters:
- `OPCODE_W`, 5: opcode field width.
- `OP_LD`, 5'b00000: load opcode.
- `OP_LDI`, 5'b00001: load-immediate opcode.
- `OP_ST`, 5'b00010: store opcode.
- `TIMEOUT`, 15: maximum wait cycles per memory access. Must be at least 1. Used only with `MEMSEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `start` in 1: begin one instruction. Sampled only in IDLE.
- `ir_opcode` in OPCODE_W: IR[31:27], valid from T3 onward.
- `mem_ready` in 1: memory access complete this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last step.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `timeout_err` out 1: one-cycle pulse on a memory timeout.
- `step` out 4: current state code.
- Datapath enables, 1 bit each: `PCout`, `MARin`, `IncPC`, `Zin` (drives ZHighIn and ZLowIn), `ZLowout`, `PCin`, `MDRin`, `Read`, `MDRout`, `IRin`, `Gra`, `Grb`, `BAout`, `Yin`, `Cout`, `Rin`, `Rout`, `Write`.

## Operation
- States and step codes: IDLE=0, T0=1 … T7=8.
- Enables decode from the registered state only (Moore). All enables not listed for a step are 0.
- IDLE: all enables 0. If `start`=1, go to T0.
- T0: `PCout`, `MARin`, `IncPC`, `Zin` → T1.
- T1: `ZLowout`, `PCin`, `MDRin`, `Read`. Hold until `mem_ready`, then → T2.
- T2: `MDRout`, `IRin` → T3.
- T3: decode `ir_opcode`.
  - Not LD/LDI/ST: no enables, pulse `illegal`, → IDLE, no `done`.
  - Otherwise: `Grb`, `BAout`, `Yin` → T4.
- T4: `Cout`, `Zin` (ALU add; Y + C sign-extended, 32-bit wrap-around) → T5.
- T5:
  - LDI: `ZLowout`, `Gra`, `Rin`; this is the last step.
  - LD/ST: `ZLowout`, `MARin` → T6.
- T6:
  - LD: `Read`, `MDRin`; hold until `mem_ready`.
  - ST: `Gra`, `Rout`, `MDRin`; one cycle.
  - Then → T7.
- T7:
  - LD: `MDRout`, `Gra`, `Rin`; last step.
  - ST: `MDRout`, `Write`; hold until `mem_ready`; last step.
- Last step complete → IDLE, `done`=1 for the IDLE cycle that follows.
- `start` while `busy` is ignored. `start` on the same edge that `done` is set is accepted: IDLE→T0 directly, `done` still pulses.
- The opcode is latched internally at T3. Later changes on `ir_opcode` do not affect the path taken.

## Timing
- Reset (`clr`=0, async): state IDLE, every output 0, `step`=0, wait counter 0. Reset mid-instruction aborts immediately with no `done`.
- Latency from `start` sampled to `done`, with `mem_ready` constantly 1:
  - LD: 9 cycles.
  - ST: 9 cycles.
  - LDI: 7 cycles.
- Each cycle `mem_ready`=0 in a wait step (T1; T6 for LD; T7 for ST) adds exactly one cycle.
- `mem_ready` is ignored outside wait steps.
- A `Read`/`Write` enable held through a wait step stays constant; no glitching between cycles.

## Configuration
- `MEMSEQ_TIMEOUT_EN` defined:
  - A wait counter counts consecutive `mem_ready`=0 cycles within a wait step and clears on every step change.
  - When it reaches `TIMEOUT`: → IDLE, `timeout_err` pulses one cycle, no `done`.
  - `mem_ready`=1 in the same cycle as the limit wins: the access completes normally.
- Undefined: waits forever, `timeout_err` tied 0, no counter logic.

## Structure
- Package `memseq_pkg`: state enum with step codes, default opcode constants, operation class enum (LD/LDI/ST/ILLEGAL).
- Sub-module `memseq_wait_ctr`: wait/timeout counter with `clr_cnt`, `inc`, and `expired` outputs. Instantiated only under `MEMSEQ_TIMEOUT_EN`.

## Test plan
- ST, `ir_opcode`=5'b00010 (IR 0x10880007), `mem_ready`=1 → `step` 1..8; `Write`=1 only at step 8; `done` 9 cycles after `start`.
- LD with `mem_ready` low 3 cycles in T6 → `Read`+`MDRin` held 4 cycles; `done` at cycle 12.
- LDI (5'b00001) → `Gra`+`Rin`+`ZLowout` at T5; no `MARin` after T0; `done` at cycle 7.
- `ir_opcode`=5'b11111 → `illegal` pulse after T3, back to IDLE, `done` stays 0.
- `clr` low during T6 of ST → all outputs 0 asynchronously, `Write` never asserted.
- With `MEMSEQ_TIMEOUT_EN`, `TIMEOUT`=4, `mem_ready`=0 in T1 → `timeout_err` pulse after 4 wait cycles, then IDLE; a new `start` fetches normally.

Source files
------------

// File: rtl/memseq_pkg.sv
// Shared types for the one-bus CPU control-step sequencer: state codes
// (which double as the visible step number), opcode defaults, the decoded
// operation class and the bundle of datapath enables.
package memseq_pkg;

   // Step codes are the state encoding itself, so `step` is the state register.
   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8
   } state_e;

   typedef enum logic [1:0] {
      OPC_LD      = 2'd0,
      OPC_LDI     = 2'd1,
      OPC_ST      = 2'd2,
      OPC_ILLEGAL = 2'd3
   } op_class_e;

   localparam int unsigned OPCODE_W_DEF = 5;
   localparam logic [4:0]  OP_LD_DEF    = 5'b00000;
   localparam logic [4:0]  OP_LDI_DEF   = 5'b00001;
   localparam logic [4:0]  OP_ST_DEF    = 5'b00010;

   // One bit per datapath enable, in the order the ports are listed.
   typedef struct packed {
      logic pc_out;
      logic mar_in;
      logic inc_pc;
      logic z_in;
      logic zlow_out;
      logic pc_in;
      logic mdr_in;
      logic mem_read;
      logic mdr_out;
      logic ir_in;
      logic gra;
      logic grb;
      logic ba_out;
      logic y_in;
      logic c_out;
      logic r_in;
      logic r_out;
      logic mem_write;
   } dp_en_t;

   // Steps that stall on mem_ready: instruction fetch, LD data read, ST write.
   function automatic logic is_wait_step(input state_e s, input op_class_e op);
      return (s == S_T1) || ((s == S_T6) && (op == OPC_LD)) ||
             ((s == S_T7) && (op == OPC_ST));
   endfunction

endpackage

// File: rtl/memseq_wait_ctr.sv
// Memory wait-state counter. Counts consecutive stalled cycles in a wait
// step; `expired` flags the stalled cycle that reaches TIMEOUT so the
// sequencer can abandon the access on that same edge.
module memseq_wait_ctr #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_cnt,
   input  logic inc,
   output logic expired
);

   // Holds 0..TIMEOUT-1; the count never passes the limit because expiry
   // always changes step, which clears it.
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = inc && (cnt_q == CW'(TIMEOUT - 1));

   // Next count: a step change wins over a stall.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_cnt) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_step_sequencer.sv
// Hardwired control-step sequencer for the one-bus CPU: fetch, decode and
// the ld / ldi / st execute steps, with memory wait states on mem_ready.
// Optional feature macro: MEMSEQ_TIMEOUT_EN (bounded memory waits with a
// timeout_err pulse; without it waits are unbounded and timeout_err is 0).
//
// Memory handshake: in a wait step (T1 fetch, T6 for LD, T7 for ST) the
// Read/Write enable is held steady by the state; the step completes on the
// first rising edge where mem_ready=1. mem_ready is ignored in every other step.
module mem_step_sequencer
   import memseq_pkg::*;
#(
   parameter int unsigned          OPCODE_W = OPCODE_W_DEF,
   parameter logic [OPCODE_W-1:0]  OP_LD    = OPCODE_W'(OP_LD_DEF),
   parameter logic [OPCODE_W-1:0]  OP_LDI   = OPCODE_W'(OP_LDI_DEF),
   parameter logic [OPCODE_W-1:0]  OP_ST    = OPCODE_W'(OP_ST_DEF),
   parameter int unsigned          TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                start,
   input  logic [OPCODE_W-1:0] ir_opcode,
   input  logic                mem_ready,
   output logic                busy,
   output logic                done,
   output logic                illegal,
   output logic                timeout_err,
   output logic [3:0]          step,
   output logic                PCout,
   output logic                MARin,
   output logic                IncPC,
   output logic                Zin,
   output logic                ZLowout,
   output logic                PCin,
   output logic                MDRin,
   output logic                Read,
   output logic                MDRout,
   output logic                IRin,
   output logic                Gra,
   output logic                Grb,
   output logic                BAout,
   output logic                Yin,
   output logic                Cout,
   output logic                Rin,
   output logic                Rout,
   output logic                Write
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_step_sequencer: TIMEOUT must be at least 1");
   end

   state_e    state_q, state_d;
   op_class_e op_q, op_d;
   logic      done_q, done_d;
   logic      illegal_q, illegal_d;
   logic      tmo_q, tmo_d;
   op_class_e cur_class;
   logic      expired;
   dp_en_t    en;

   // Classify the opcode currently presented by the IR (meaningful from T3).
   always_comb begin
      cur_class = OPC_ILLEGAL;
      if (ir_opcode == OP_LD) begin
         cur_class = OPC_LD;
      end else if (ir_opcode == OP_LDI) begin
         cur_class = OPC_LDI;
      end else if (ir_opcode == OP_ST) begin
         cur_class = OPC_ST;
      end
   end

`ifdef MEMSEQ_TIMEOUT_EN
   logic in_stall;
   assign in_stall = is_wait_step(state_q, op_q) && !mem_ready;

   memseq_wait_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_ctr (
      .clk     (clk),
      .rst_n   (clr),
      .clr_cnt (state_d != state_q),
      .inc     (in_stall),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   // Next-state and completion pulses; mem_ready=1 beats expiry in the same cycle.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      tmo_d     = 1'b0;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1: begin
            if (mem_ready) begin
               state_d = S_T2;
            end else if (expired) begin
               state_d = S_IDLE;
               tmo_d   = 1'b1;
            end
         end
         S_T2:   state_d = S_T3;
         S_T3: begin
            // Latch the class so later IR changes cannot redirect the path.
            op_d = cur_class;
            if (cur_class == OPC_ILLEGAL) begin
               state_d   = S_IDLE;
               illegal_d = 1'b1;
            end else begin
               state_d = S_T4;
            end
         end
         S_T4:   state_d = S_T5;
         S_T5: begin
            if (op_q == OPC_LDI) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = S_T6;
            end
         end
         S_T6: begin
            if ((op_q == OPC_LD) && !mem_ready) begin
               if (expired) begin
                  state_d = S_IDLE;
                  tmo_d   = 1'b1;
               end
            end else begin
               state_d = S_T7;
            end
         end
         S_T7: begin
            if ((op_q == OPC_ST) && !mem_ready) begin
               if (expired) begin
                  state_d = S_IDLE;
                  tmo_d   = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, latched operation class and one-cycle status pulses.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= S_IDLE;
         op_q      <= OPC_LD;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         tmo_q     <= tmo_d;
      end
   end

   // Datapath enables per step. T3 looks at the live opcode (the IR is loaded
   // at the end of T2) so an illegal opcode drives nothing; later steps use
   // the latched class.
   always_comb begin
      en = '0;
      unique case (state_q)
         S_T0: begin
            en.pc_out = 1'b1; en.mar_in = 1'b1; en.inc_pc = 1'b1; en.z_in = 1'b1;
         end
         S_T1: begin
            en.zlow_out = 1'b1; en.pc_in = 1'b1; en.mdr_in = 1'b1; en.mem_read = 1'b1;
         end
         S_T2: begin
            en.mdr_out = 1'b1; en.ir_in = 1'b1;
         end
         S_T3: begin
            if (cur_class != OPC_ILLEGAL) begin
               en.grb = 1'b1; en.ba_out = 1'b1; en.y_in = 1'b1;
            end
         end
         S_T4: begin
            en.c_out = 1'b1; en.z_in = 1'b1;
         end
         S_T5: begin
            en.zlow_out = 1'b1;
            if (op_q == OPC_LDI) begin
               en.gra = 1'b1; en.r_in = 1'b1;
            end else begin
               en.mar_in = 1'b1;
            end
         end
         S_T6: begin
            en.mdr_in = 1'b1;
            if (op_q == OPC_LD) begin
               en.mem_read = 1'b1;
            end else begin
               en.gra = 1'b1; en.r_out = 1'b1;
            end
         end
         S_T7: begin
            en.mdr_out = 1'b1;
            if (op_q == OPC_ST) begin
               en.mem_write = 1'b1;
            end else begin
               en.gra = 1'b1; en.r_in = 1'b1;
            end
         end
         default: en = '0;
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign step        = state_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign timeout_err = tmo_q;

   assign PCout   = en.pc_out;
   assign MARin   = en.mar_in;
   assign IncPC   = en.inc_pc;
   assign Zin     = en.z_in;
   assign ZLowout = en.zlow_out;
   assign PCin    = en.pc_in;
   assign MDRin   = en.mdr_in;
   assign Read    = en.mem_read;
   assign MDRout  = en.mdr_out;
   assign IRin    = en.ir_in;
   assign Gra     = en.gra;
   assign Grb     = en.grb;
   assign BAout   = en.ba_out;
   assign Yin     = en.y_in;
   assign Cout    = en.c_out;
   assign Rin     = en.r_in;
   assign Rout    = en.r_out;
   assign Write   = en.mem_write;

endmodule
